// File: rtl/rssb_run_sequencer_if.sv
// Run-control bundle between the RSSB sequencer and host, CPU and data memory.
// The sequencer takes the master view; the surrounding system takes the slave view.
interface rssb_run_sequencer_if #(
  parameter int DW = 1,
  parameter int AW = 5
);
  logic          start;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          ph0;
  logic          ph1;
  logic          ph2;
  logic          cpu_rst_n;
  logic          cpu_halt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic [1:0]    result;
  logic          timeout;

  modport master (
    input  start, op_a, op_b,
    input  cpu_halt, mem_rdata,
    output ph0, ph1, ph2, cpu_rst_n,
    output mem_we, mem_addr, mem_wdata,
    output busy, done, result, timeout
  );

  modport slave (
    output start, op_a, op_b,
    output cpu_halt, mem_rdata,
    input  ph0, ph1, ph2, cpu_rst_n,
    input  mem_we, mem_addr, mem_wdata,
    input  busy, done, result, timeout
  );
endinterface

// File: rtl/rssb_run_sequencer.sv
// RSSB run sequencer: phase enables, operand load, CPU reset/halt watch,
// flag readback and result decode.
module rssb_run_sequencer #(
  parameter int DW      = 1,
  parameter int AW      = 5,
  parameter int TIMEOUT = 4096
) (
  input logic                  clk,
  input logic                  rst,
  rssb_run_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RSTP, RUN, READ, DONE
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          ph0_q;
  logic          ph1_q;
  logic          ph2_q;
  logic          crn_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] opb_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    res_q;
  logic          to_q;
  logic [12:0]   ph1c_q;
  logic [12:0]   ph1c_d;
  logic          hs_q;
  logic [1:0]    rd_q;
  logic          f2_q;
  logic          f3_q;
  logic [2:0]    fl;
  logic [1:0]    res_dec;

  assign ph1c_d = ph1c_q + 13'd1;

  // Flag f4 is taken straight off the read port on the last READ cycle.
  assign fl = {f2_q, f3_q, bus.mem_rdata[0]};

  always_comb begin
    res_dec = 2'b00;
    unique case (1'b1)
      fl == 3'b100: res_dec = 2'b01;
      fl == 3'b010: res_dec = 2'b10;
      fl == 3'b001: res_dec = 2'b11;
      default:      res_dec = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
      ph0_q <= 1'b0;
      ph1_q <= 1'b0;
      ph2_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 3'd1;
      ph0_q <= (cnt_q == 3'd3);
      ph1_q <= (cnt_q == 3'd5);
      ph2_q <= (cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crn_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      opb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 2'b00;
      to_q    <= 1'b0;
      ph1c_q  <= '0;
      hs_q    <= 1'b0;
      rd_q    <= 2'd0;
      f2_q    <= 1'b0;
      f3_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            opb_q   <= bus.op_b;
            busy_q  <= 1'b1;
            res_q   <= 2'b00;
            to_q    <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= bus.op_a;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (addr_q == AW'(4)) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            state_q <= RSTP;
          end else begin
            addr_q  <= addr_q + AW'(1);
            wdata_q <= (addr_q == '0) ? opb_q : '0;
          end
        end
        RSTP: begin
          if (ph1_q) begin
            crn_q   <= 1'b1;
            ph1c_q  <= '0;
            hs_q    <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (ph1_q) begin
            ph1c_q <= ph1c_d;
            hs_q   <= bus.cpu_halt;
            // Halt must be seen on two consecutive ph1 samples.
            if (bus.cpu_halt && hs_q) begin
              crn_q   <= 1'b0;
              addr_q  <= AW'(2);
              rd_q    <= 2'd0;
              state_q <= READ;
            end else if (ph1c_d == 13'(TIMEOUT)) begin
              crn_q   <= 1'b0;
              done_q  <= 1'b1;
              res_q   <= 2'b00;
              to_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        READ: begin
          rd_q <= rd_q + 2'd1;
          unique case (rd_q)
            2'd0: addr_q <= AW'(3);
            2'd1: begin
              addr_q <= AW'(4);
              f2_q   <= bus.mem_rdata[0];
            end
            2'd2: begin
              addr_q <= '0;
              f3_q   <= bus.mem_rdata[0];
            end
            2'd3: begin
              done_q  <= 1'b1;
              res_q   <= res_dec;
              state_q <= DONE;
            end
            default: rd_q <= 2'd0;
          endcase
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ph0       = ph0_q;
  assign bus.ph1       = ph1_q;
  assign bus.ph2       = ph2_q;
  assign bus.cpu_rst_n = crn_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rssb_run_sequencer.sv
// Bench for rssb_run_sequencer: cycle-level schedule model plus memory/CPU
// stand-in, with a few hand-computed latencies and results.
module tb_rssb_run_sequencer;
  localparam int DW = 1;
  localparam int AW = 5;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rssb_run_sequencer_if #(.DW(DW), .AW(AW)) bus();

  rssb_run_sequencer #(
    .DW(DW), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n = -1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, n, got, exp);
    end
  endtask

  // Data memory plus the CPU writing its flags once it is running.
  logic [DW-1:0] mem [32];
  logic          cpu_wr = 1'b0;
  logic [2:0]    flags;
  logic [15:0]   pat;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (cpu_wr) begin
      mem[2] <= DW'(flags[2]);
      mem[3] <= DW'(flags[1]);
      mem[4] <= DW'(flags[0]);
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  logic s_rst, s_start;
  logic [DW-1:0] s_a, s_b;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_start <= bus.start;
    s_a     <= bus.op_a;
    s_b     <= bus.op_b;
  end

  function automatic logic [1:0] dec(input logic [2:0] f);
    case (f)
      3'b100:  return 2'b01;
      3'b010:  return 2'b10;
      3'b001:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Model: a run is described by start cycle s, ph1 exit cycle r,
  // halt/timeout sample cycle m and done cycle d.
  bit act, busy_prev, samp_prev, tmo, hs;
  int s, r, m, d, k;
  logic [DW-1:0] a_l, b_l;
  logic [2:0]  fl_m;
  logic [15:0] pat_m;
  logic [1:0]  res_h, e_res_d;
  logic        to_h, e_to_d;

  always @(negedge clk) begin
    logic e_busy, e_done, e_we, e_crn, e_to;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0]    e_res;
    cpu_wr = 1'b0;
    if (s_rst === 1'b1) begin
      n = 0; act = 0; res_h = 0; to_h = 0;
      busy_prev = 0; samp_prev = 0;
      bus.cpu_halt = 1'b0;
    end else if (n >= 0) begin
      n++;
      if (s_start && !busy_prev) begin
        act = 1; s = n; a_l = s_a; b_l = s_b;
        r = s + 5;
        while (r % 8 != 6) r++;
        k = 0; hs = 0; m = -1; d = -1; tmo = 0;
        res_h = 0; to_h = 0; samp_prev = 0;
        fl_m = flags; pat_m = pat;
        bus.cpu_halt = pat_m[0];
      end
    end
    if (n >= 0) begin
      if (act && d >= 0 && n > d) act = 0;
      e_busy = act;
      e_done = act && (n == d);
      e_we   = act && (n <= s + 4);
      e_addr = '0;
      if (e_we) e_addr = AW'(n - s);
      else if (act && m >= 0 && !tmo && n >= m + 1 && n <= m + 3)
        e_addr = AW'(n - m + 1);
      e_wd = '0;
      if (act && n == s) e_wd = a_l;
      if (act && n == s + 1) e_wd = b_l;
      e_crn = act && n > r && (m < 0 || n <= m);
      e_res = act ? (e_done ? e_res_d : 2'b00) : res_h;
      e_to  = act ? (e_done ? e_to_d : 1'b0) : to_h;
      if (e_done) begin res_h = e_res_d; to_h = e_to_d; end

      chk("ph0", 32'(bus.ph0), 32'(n % 8 == 4));
      chk("ph1", 32'(bus.ph1), 32'(n % 8 == 6));
      chk("ph2", 32'(bus.ph2), 32'(n > 0 && n % 8 == 0));
      chk("cpu_rst_n", 32'(bus.cpu_rst_n), 32'(e_crn));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("result", 32'(bus.result), 32'(e_res));
      chk("timeout", 32'(bus.timeout), 32'(e_to));
      busy_prev = e_busy;

      if (act) begin
        if (samp_prev)
          bus.cpu_halt = (m < 0 && k < 16) ? pat_m[k] : 1'b0;
        samp_prev = 0;
        if (n == r + 1) cpu_wr = 1'b1;
        if (m < 0 && n > r && (n - r) % 8 == 0) begin
          k++;
          samp_prev = 1;
          if (bus.cpu_halt && hs) begin
            m = n; d = n + 5;
            e_res_d = dec(fl_m); e_to_d = 1'b0;
          end else if (k == TO) begin
            m = n; d = n + 1; tmo = 1;
            e_res_d = 2'b00; e_to_d = 1'b1;
          end
          hs = bus.cpu_halt;
        end
      end
    end
  end

  task automatic go(input logic a, input logic b);
    bus.op_a  = DW'(a);
    bus.op_b  = DW'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycles from CPU release to the done pulse; optional start poke in RUN.
  task automatic run_wait(input bit poke, output int lat);
    int c;
    c = 0;
    lat = 0;
    while (bus.cpu_rst_n !== 1'b1 && c < 200) begin
      @(negedge clk); c++;
    end
    if (poke) begin
      bus.op_a = '0; bus.op_b = '0; bus.start = 1'b1;
      @(negedge clk); c++; lat++;
      bus.start = 1'b0;
    end
    while (bus.done !== 1'b1 && c < 600) begin
      @(negedge clk); c++; lat++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_wait: got no done after %0d cycles, required done", c);
    end
  endtask

  task automatic ph0_after_rst();
    int c;
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (bus.ph0 !== 1'b1 && c < 20);
    chk("ph0_first", 32'(c), 32'd4);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    flags = 3'b000;
    pat = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_crn", 32'(bus.cpu_rst_n), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    ph0_after_rst();

    // op_a=1 op_b=0, flags 100, halt on first two samples
    flags = 3'b100; pat = 16'b11;
    go(1'b1, 1'b0);
    run_wait(1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd20);
    chk("t1_result", 32'(bus.result), 32'(2'b01));
    chk("t1_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk);
    chk("t1_mem0", 32'(mem[0]), 32'd1);
    chk("t1_mem1", 32'(mem[1]), 32'd0);
    chk("t1_hold", 32'(bus.result), 32'(2'b01));

    // op_a=op_b=1, flags 010, halt late
    flags = 3'b010; pat = 16'b1100;
    go(1'b1, 1'b1);
    run_wait(1'b0, lat);
    chk("t2_lat", 32'(lat), 32'd36);
    chk("t2_result", 32'(bus.result), 32'(2'b10));

    // start held from the done cycle: first ignored, second accepted
    flags = 3'b001; pat = 16'b1101;
    bus.op_a = 1'b0; bus.op_b = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("chain_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("chain_busy", 32'(bus.busy), 32'd1);
    run_wait(1'b0, lat);
    chk("t3_lat", 32'(lat), 32'd36);
    chk("t3_result", 32'(bus.result), 32'(2'b11));
    @(negedge clk);
    chk("t3_mem0", 32'(mem[0]), 32'd0);
    chk("t3_mem1", 32'(mem[1]), 32'd1);

    // halt never seen: timeout after TO samples
    flags = 3'b000; pat = 16'h0;
    go(1'b0, 1'b0);
    run_wait(1'b0, lat);
    chk("t4_lat", 32'(lat), 32'd64);
    chk("t4_timeout", 32'(bus.timeout), 32'd1);
    chk("t4_result", 32'(bus.result), 32'd0);
    @(negedge clk);

    // invalid flags, start poked during RUN
    flags = 3'b110; pat = 16'b11;
    go(1'b1, 1'b1);
    run_wait(1'b1, lat);
    chk("t5_lat", 32'(lat), 32'd20);
    chk("t5_result", 32'(bus.result), 32'd0);
    chk("t5_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk);

    // reset in RUN, then a fresh run
    flags = 3'b100; pat = 16'b11;
    go(1'b1, 1'b0);
    lat = 0;
    while (bus.cpu_rst_n !== 1'b1 && lat < 200) begin
      @(negedge clk); lat++;
    end
    chk("t6_in_run", 32'(bus.cpu_rst_n), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_crn", 32'(bus.cpu_rst_n), 32'd0);
    chk("t6_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    ph0_after_rst();
    go(1'b1, 1'b0);
    run_wait(1'b0, lat);
    chk("t6_lat", 32'(lat), 32'd20);
    chk("t6_result", 32'(bus.result), 32'(2'b01));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
